censor_out_stage: RTL
=====================

Name: censor_out_stage

Overview:
Parametrised output stage of the censor pipeline. Replaces masked input characters with a programmable mask character, drops NUL characters, and buffers results in a small FIFO behind a valid/ready handshake. It sits between the mask-generation logic and the character sink (UART/AXI-stream side). It also keeps a saturating count of replaced characters for status readout.

Parameters:
CHAR_W, 8, character width in bits
MASK_CHAR, 8'h2A, replacement character ('*'); width CHAR_W
DEPTH, 4, output FIFO depth in entries; power of two, >=2
CNT_W, 16, width of masked-character counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; asynchronous, active-low
in_char  in  CHAR_W  input character
in_mask  in  1  1 = character is to be censored
in_valid  in  1  input character/mask valid
in_ready  out  1  stage can accept a character
mode  in  2  0 = full mask, 1 = keep-first, 2/3 = passthrough
out_char  out  CHAR_W  head-of-FIFO character
out_valid  out  1  out_char valid
out_ready  in  1  sink accepts out_char
level  out  $clog2(DEPTH)+1  current FIFO occupancy
cnt_clr  in  1  synchronous clear of masked_count
masked_count  out  CNT_W  number of characters replaced by MASK_CHAR

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, level=0, out_valid=0, in_ready=1, masked_count=0, run flag=0. out_char is don't-care while out_valid=0; implementation drives 0.
- Handshake: input accepted on a rising edge when in_valid && in_ready. Output popped on a rising edge when out_valid && out_ready.
- in_ready = (level != DEPTH). There is no write-through-when-full: a full FIFO refuses input even if a pop happens in the same cycle.
- out_valid = (level != 0). out_char = FIFO head, stable while out_valid && !out_ready.
- NUL handling: an accepted in_char == 0 is consumed but not written. It does not change the run flag or masked_count, and in_mask is ignored.
- Transform of an accepted non-NUL character, with mode sampled in the same cycle:
  - mode 0: in_mask=1 -> MASK_CHAR, else in_char.
  - mode 1: in_mask=1 and run flag=0 -> in_char unchanged, run flag set. in_mask=1 and run flag=1 -> MASK_CHAR. in_mask=0 -> in_char, run flag cleared.
  - mode 2/3: in_char unchanged. Run flag is updated exactly as in mode 1, so switching into mode 1 mid-word is consistent.
- Latency: a character accepted at edge N into an empty FIFO gives out_valid=1 and the transformed char on out_char after edge N. One cycle, no combinational in->out path. Sustained throughput is 1 char/cycle when out_ready is held high.
- Simultaneous push and pop (FIFO not full): level unchanged and ordering preserved. With level=1 the popped head is replaced by the new character.
- Pointers are log2(DEPTH) bits and wrap naturally. level is the explicit occupancy counter.
- masked_count increments by 1 for each character written as MASK_CHAR. A character that equals MASK_CHAR in the input but passes through unmasked does not count. The counter saturates at 2^CNT_W-1. cnt_clr=1 zeroes it and takes priority over a same-cycle increment.
- Reset asserted mid-transfer discards all FIFO contents and the run flag immediately. No character is emitted after rst_n is released until a new one is accepted.

Test Plan:
1. Reset then mode=0, out_ready=1; send 'a','b'(mask),'c' back-to-back -> out_char sequence 0x61,0x2A,0x63, each 1 cycle after acceptance; masked_count=1.
2. mode=1; send "shit" with mask=1,1,1,1 then ' ' with mask=0, then "damn" all masked -> output "s***" ' ' "d***"; masked_count=6.
3. Send 0x41, 0x00, 0x42 (0x00 with mask=1) -> output 0x41,0x42 only; level never exceeds 2; masked_count unchanged.
4. out_ready=0, DEPTH=4; push 5 chars -> in_ready drops after 4th acceptance, level=4, 5th held. Raise out_ready for one cycle: the 5th char is not accepted that cycle (no write-through) and is accepted the next. Order is preserved.
5. CNT_W=4: mask 17 chars in mode 0 -> masked_count saturates at 15. Assert cnt_clr together with a masked char -> count=0.
6. Fill FIFO to 3 entries, pulse rst_n low between edges -> out_valid=0, level=0, in_ready=1 immediately (asynchronously), before the next clock edge.

Source files
------------

// File: rtl/censor_out_stage.sv
// rtl/censor_out_stage.sv - censor output stage: mask substitution, NUL drop, output FIFO, masked counter
module censor_out_stage #(
  parameter int                 CHAR_W    = 8,
  parameter logic [CHAR_W-1:0]  MASK_CHAR = 8'h2A,
  parameter int                 DEPTH     = 4,
  parameter int                 CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHAR_W-1:0]          in_char,
  input  logic                       in_mask,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 mode,
  output logic [CHAR_W-1:0]          out_char,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       cnt_clr,
  output logic [CNT_W-1:0]           masked_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              run_flag;
  logic              run_next;
  logic              do_mask;
  logic              push;
  logic              wr_en;
  logic              pop;
  logic [CHAR_W-1:0] wr_char;

  assign in_ready  = (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign out_char  = out_valid ? mem[rd_ptr] : '0;

  assign push  = in_valid && in_ready;
  assign wr_en = push && (in_char != '0);
  assign pop   = out_valid && out_ready;

  // The run flag tracks masked words in every non-zero mode so that
  // entering keep-first mode mid-word behaves as if it had been active.
  always_comb begin
    do_mask  = 1'b0;
    run_next = run_flag;
    if (mode == 2'd0) begin
      do_mask = in_mask;
    end else if (in_mask) begin
      do_mask  = (mode == 2'd1) && run_flag;
      run_next = 1'b1;
    end else begin
      run_next = 1'b0;
    end
  end

  assign wr_char = do_mask ? MASK_CHAR : in_char;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_char;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      run_flag     <= 1'b0;
      masked_count <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr   <= wr_ptr + 1'b1;
        run_flag <= run_next;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (cnt_clr) begin
        masked_count <= '0;
      end else if (wr_en && do_mask && (masked_count != {CNT_W{1'b1}})) begin
        masked_count <= masked_count + 1'b1;
      end
    end
  end

endmodule
